// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad code lock.
package keypad_pkg;

   localparam int unsigned KEY_W = 4;

   localparam logic [KEY_W-1:0] KEY_ENTER_DEF = 4'hE;
   localparam logic [KEY_W-1:0] KEY_CLEAR_DEF = 4'hC;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACK     = 3'd1,
      ST_RELEASE = 3'd2,
      ST_CHECK   = 3'd3,
      ST_OPEN    = 3'd4,
      ST_LOCKOUT = 3'd5
   } lock_state_e;

endpackage

// File: rtl/lock_timer.sv
// Loadable down counter that stops at zero; shared by the open window and the lockout.
module lock_timer #(
   parameter int unsigned CNT_W = 24
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_zero_c
);

   logic [CNT_W-1:0] r_cnt;

   // Load on request, otherwise count down and hold at terminal count
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/keypad_code_lock.sv
// Keypad code lock: drains keys over KeyReady/KeyRead, checks the entry against
// the stored code, opens a timed window or enforces an alarm lockout.
// Optional feature macro: KEYPAD_CODE_LOCK_PROGRAM_EN (re-program the code while open).
module keypad_code_lock
   import keypad_pkg::*;
#(
   parameter int unsigned            CODE_LEN       = 4,
   parameter logic [CODE_LEN*4-1:0]  CODE_INIT      = 16'h1234,
   parameter logic [KEY_W-1:0]       KEY_ENTER      = KEY_ENTER_DEF,
   parameter logic [KEY_W-1:0]       KEY_CLEAR      = KEY_CLEAR_DEF,
   parameter int unsigned            MAX_FAIL       = 3,
   parameter int unsigned            UNLOCK_CYCLES  = 5000000,
   parameter int unsigned            LOCKOUT_CYCLES = 10000000
) (
   input  logic             Clock,
   input  logic             ResetButton,
   input  logic             KeyReady,
   input  logic [KEY_W-1:0] DataIn,
   output logic             KeyRead,
   output logic             Unlocked,
   output logic             Alarm,
   output logic [3:0]       EntryCount,
   output logic [3:0]       FailCount
);

   localparam int unsigned CODE_W  = CODE_LEN * KEY_W;
   localparam int unsigned TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   lock_state_e       r_state, w_state_nxt;
   logic [KEY_W-1:0]  r_key;
   logic [CODE_W-1:0] r_buf, w_buf_nxt;
   logic [3:0]        r_entry_cnt, w_entry_cnt_nxt;
   logic [3:0]        r_fail_cnt, w_fail_cnt_nxt;
   logic              r_overflow, w_overflow_nxt;
   logic              r_unlocked, w_unlocked_nxt;
   logic              r_alarm, w_alarm_nxt;
   logic              r_key_read;
   logic              w_tmr_load;
   logic [TMR_W-1:0]  w_tmr_val;
   logic              w_tmr_zero_c;
   logic [CODE_W-1:0] w_code;
   logic              w_prog;
   logic              w_is_digit, w_full, w_match, w_expire;

`ifdef KEYPAD_CODE_LOCK_PROGRAM_EN
   localparam bit PROG_EN = 1'b1;
   logic [CODE_W-1:0] r_code;

   // Stored code, rewritten by a full-length ENTER while the lock is open
   always_ff @(posedge Clock or negedge ResetButton) begin
      if (!ResetButton) begin
         r_code <= CODE_INIT;
      end else if (w_prog) begin
         r_code <= r_buf;
      end
   end

   assign w_code = r_code;
`else
   localparam bit PROG_EN = 1'b0;
   assign w_code = CODE_INIT;
`endif

   assign w_is_digit = (r_key != KEY_ENTER) && (r_key != KEY_CLEAR);
   assign w_full     = (r_entry_cnt == 4'(CODE_LEN));
   assign w_match    = w_full && !r_overflow && (r_buf == w_code);
   assign w_expire   = w_tmr_zero_c && (r_unlocked || r_alarm);
   assign w_prog     = PROG_EN && (r_state == ST_ACK) && r_unlocked && !r_alarm &&
                       (r_key == KEY_ENTER) && w_full && !r_overflow;

   lock_timer #(
      .CNT_W (TMR_W)
   ) u_timer (
      .i_clk      (Clock),
      .i_rst_n    (ResetButton),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_zero_c   (w_tmr_zero_c)
   );

   // State register
   always_ff @(posedge Clock or negedge ResetButton) begin
      if (!ResetButton) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state; the resting state follows the open/alarm mode flags
   always_comb begin
      lock_state_e v_home;
      w_state_nxt = r_state;
      v_home      = w_alarm_nxt ? ST_LOCKOUT : (w_unlocked_nxt ? ST_OPEN : ST_IDLE);
      case (r_state)
         ST_IDLE, ST_OPEN, ST_LOCKOUT: w_state_nxt = KeyReady ? ST_ACK : v_home;
         ST_ACK:     w_state_nxt = (!r_alarm && !r_unlocked && (r_key == KEY_ENTER)) ? ST_CHECK : ST_RELEASE;
         ST_CHECK:   w_state_nxt = ST_RELEASE;
         ST_RELEASE: w_state_nxt = KeyReady ? ST_RELEASE : v_home;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // Output and datapath next values: key processing, code check, timer control
   always_comb begin
      w_buf_nxt       = r_buf;
      w_entry_cnt_nxt = r_entry_cnt;
      w_overflow_nxt  = r_overflow;
      w_fail_cnt_nxt  = r_fail_cnt;
      w_unlocked_nxt  = r_unlocked;
      w_alarm_nxt     = r_alarm;
      w_tmr_load      = 1'b0;
      w_tmr_val       = TMR_W'(UNLOCK_CYCLES - 1);

      if (w_expire) begin
         w_unlocked_nxt = 1'b0;
         if (r_alarm) begin
            w_alarm_nxt    = 1'b0;
            w_fail_cnt_nxt = 4'd0;
         end
      end

      case (r_state)
         ST_ACK: begin
            if (r_alarm) begin
               w_entry_cnt_nxt = r_entry_cnt;
            end else if (r_unlocked) begin
               if (r_key == KEY_CLEAR) begin
                  w_unlocked_nxt  = 1'b0;
                  w_entry_cnt_nxt = 4'd0;
                  w_overflow_nxt  = 1'b0;
               end else if (w_prog) begin
                  w_unlocked_nxt  = 1'b1;
                  w_tmr_load      = 1'b1;
                  w_entry_cnt_nxt = 4'd0;
                  w_overflow_nxt  = 1'b0;
               end else if (r_key == KEY_ENTER) begin
                  w_entry_cnt_nxt = 4'd0;
                  w_overflow_nxt  = 1'b0;
               end else if (PROG_EN) begin
                  if (w_full) begin
                     w_overflow_nxt = 1'b1;
                  end else begin
                     w_buf_nxt       = (r_buf << KEY_W) | CODE_W'(r_key);
                     w_entry_cnt_nxt = r_entry_cnt + 4'd1;
                  end
               end
            end else if (r_key == KEY_CLEAR) begin
               w_entry_cnt_nxt = 4'd0;
               w_overflow_nxt  = 1'b0;
            end else if (w_is_digit) begin
               if (w_full) begin
                  w_overflow_nxt = 1'b1;
               end else begin
                  w_buf_nxt       = (r_buf << KEY_W) | CODE_W'(r_key);
                  w_entry_cnt_nxt = r_entry_cnt + 4'd1;
               end
            end
         end
         ST_CHECK: begin
            w_entry_cnt_nxt = 4'd0;
            w_overflow_nxt  = 1'b0;
            if (w_match) begin
               w_unlocked_nxt = 1'b1;
               w_fail_cnt_nxt = 4'd0;
               w_tmr_load     = 1'b1;
            end else begin
               w_fail_cnt_nxt = r_fail_cnt + 4'd1;
               if (w_fail_cnt_nxt >= 4'(MAX_FAIL)) begin
                  w_alarm_nxt = 1'b1;
                  w_tmr_load  = 1'b1;
                  w_tmr_val   = TMR_W'(LOCKOUT_CYCLES - 1);
               end
            end
         end
         default: begin
            w_buf_nxt = r_buf;
         end
      endcase
   end

   // Datapath and output registers; a key is captured on the edge that enters ACK
   always_ff @(posedge Clock or negedge ResetButton) begin
      if (!ResetButton) begin
         r_key       <= '0;
         r_key_read  <= 1'b0;
         r_buf       <= '0;
         r_entry_cnt <= 4'd0;
         r_fail_cnt  <= 4'd0;
         r_overflow  <= 1'b0;
         r_unlocked  <= 1'b0;
         r_alarm     <= 1'b0;
      end else begin
         if (w_state_nxt == ST_ACK) begin
            r_key <= DataIn;
         end
         r_key_read  <= (w_state_nxt == ST_ACK);
         r_buf       <= w_buf_nxt;
         r_entry_cnt <= w_entry_cnt_nxt;
         r_fail_cnt  <= w_fail_cnt_nxt;
         r_overflow  <= w_overflow_nxt;
         r_unlocked  <= w_unlocked_nxt;
         r_alarm     <= w_alarm_nxt;
      end
   end

   assign KeyRead    = r_key_read;
   assign Unlocked   = r_unlocked;
   assign Alarm      = r_alarm;
   assign EntryCount = r_entry_cnt;
   assign FailCount  = r_fail_cnt;

endmodule
